// File: rtl/p2s_serial.sv
// Parallel-to-serial frame transmitter: captures a word on a start edge and shifts it out
// on sout with a divided serial clock, then strobes en/done for the external latch.
module p2s_serial #(
    parameter int DATA_BITS    = 64,
    parameter int DIR          = 1,
    parameter int CLK_DIV      = 1,
    parameter int CLR_ON_START = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] pdata,
    output logic                 busy,
    output logic                 done,
    output logic                 sclk,
    output logic                 sclrn,
    output logic                 sout,
    output logic                 en
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t               state_q, state_d;
    logic                 start_dly_q;
    logic                 start_edge;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] shreg_shift;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 phase_q, phase_d;   // 0 = sclk low half, 1 = sclk high half
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 en_q, en_d;
    logic                 sclk_q, sclk_d;
    logic                 sclrn_q, sclrn_d;
    logic                 sout_q, sout_d;

    function automatic logic first_bit(input logic [DATA_BITS-1:0] w);
        return (DIR == 1) ? w[0] : w[DATA_BITS-1];
    endfunction

    assign start_edge  = start & ~start_dly_q;
    assign shreg_shift = (DIR == 1) ? (shreg_q >> 1) : (shreg_q << 1);

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        en_d      = 1'b0;
        sclk_d    = sclk_q;
        sclrn_d   = 1'b1;
        sout_d    = sout_q;

        case (state_q)
            S_IDLE: begin
                busy_d    = 1'b0;
                sclk_d    = 1'b1;
                sout_d    = 1'b0;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                phase_d   = 1'b0;
                if (start_edge) begin
                    state_d = S_LOAD;
                    shreg_d = pdata;
                    busy_d  = 1'b1;
                    sout_d  = first_bit(pdata);
                    sclrn_d = (CLR_ON_START == 1) ? 1'b0 : 1'b1;
                end
            end

            S_LOAD: begin
                state_d   = S_SHIFT;
                sclk_d    = 1'b0;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                phase_d   = 1'b0;
            end

            S_SHIFT: begin
                if (div_cnt_q != LAST_DIV) begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end else begin
                    div_cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        // Last high phase done: the latch cycle follows with sclk parked high.
                        state_d   = S_LATCH;
                        done_d    = 1'b1;
                        en_d      = 1'b1;
                        sclk_d    = 1'b1;
                        sout_d    = 1'b0;
                        bit_cnt_d = '0;
                        phase_d   = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = shreg_shift;
                        sout_d    = first_bit(shreg_shift);
                        phase_d   = 1'b0;
                        sclk_d    = 1'b0;
                    end
                end
            end

            S_LATCH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                sclk_d  = 1'b1;
                sout_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            start_dly_q <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            en_q        <= 1'b0;
            sclk_q      <= 1'b1;
            sclrn_q     <= 1'b1;
            sout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_dly_q <= start;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            en_q        <= en_d;
            sclk_q      <= sclk_d;
            sclrn_q     <= sclrn_d;
            sout_q      <= sout_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign en    = en_q;
    assign sclk  = sclk_q;
    assign sclrn = sclrn_q;
    assign sout  = sout_q;

endmodule
